bram_port_arbiter: RTL and testbench

//   Shares one port of the 64 KB dual-port block RAM between NUM_REQ requesters.

---
 rtl/bram_port_arbiter_pkg.sv | 19 +
 rtl/bram_port_arbiter_rr_pick.sv | 34 +++
 rtl/bram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter.
//   REQ_CPU / REQ_DMA : fixed requester indices (the CPU is always index 0;
//                       the first non-CPU requester is the round-robin home slot).
//   tag_t             : read-return pipeline tag {valid, id}. The id names the
//                       requester that receives the returning read data.
package bram_port_arbiter_pkg;

  localparam int REQ_CPU  = 0;
  localparam int REQ_DMA  = 1;
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Rotating priority encoder.
//   i_req   : request vector, one bit per requester
//   i_start : index that has highest priority this cycle
//   o_gnt   : one-hot of the first set request at or after i_start (wrapping)
//   o_idx   : binary index of that request
//   o_any   : at least one request set
module bram_port_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int k;
    k     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(i_start) + i) % N;
      if (!o_any && i_req[k]) begin
        o_any    = 1'b1;
        o_gnt[k] = 1'b1;
        o_idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one port of the 64 KB block RAM between NUM_REQ requesters.
// Requester 0 is the CPU; the others are DMA / video fetch.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req/i_we              per-requester request valid and write flag
//   i_addr/i_wdata          packed per-requester address / write data
//   o_gnt                   combinational grant, one-hot or zero
//   o_rvalid/o_rdata        read return, pulse to the issuing requester
//   o_bram_we/addr/di       registered BRAM drive
//   i_bram_do               BRAM read data (valid one cycle after address edge)
//   o_busy                  read(s) in flight in the return pipeline
//
// Handshake: requester k transfers on a rising edge where i_req[k] & o_gnt[k].
// It must hold i_req/i_we/i_addr/i_wdata stable until that edge. At most one
// grant is given per cycle, and grants may be given on consecutive cycles.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int CPU_PRIO = 1,
  parameter int MAX_RUN  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_bram_we,
  output logic [ADDR_W-1:0]         o_bram_addr,
  output logic [DATA_W-1:0]         o_bram_di,
  input  logic [DATA_W-1:0]         i_bram_do,
  output logic                      o_busy
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int RUN_W = 4;
  // Lowest index the rr pointer may take; the CPU is outside the ring when it has priority.
  localparam int RR_LO = (CPU_PRIO != 0) ? REQ_DMA : REQ_CPU;

  logic [IW-1:0]      rr_q, rr_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               bram_we_q;
  logic [ADDR_W-1:0]  bram_addr_q;
  logic [DATA_W-1:0]  bram_di_q;
  tag_t               stage1_q, stage2_q;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q;

  logic               others_pending;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               cpu_wins;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      win_idx;
  logic               xfer;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  assign others_pending = |i_req[NUM_REQ-1:1];
  // With CPU priority the ring covers only the non-CPU requesters.
  assign rr_req = (CPU_PRIO != 0) ? {i_req[NUM_REQ-1:1], 1'b0} : i_req;

  bram_port_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req   (rr_req),
    .i_start (rr_q),
    .o_gnt   (pick_gnt),
    .o_idx   (pick_idx),
    .o_any   (pick_any)
  );

  // The CPU yields only once it has taken MAX_RUN grants in a row while someone else waits.
  assign cpu_wins = (CPU_PRIO != 0) && i_req[REQ_CPU] &&
                    !((run_q == RUN_W'(MAX_RUN)) && others_pending);

  always_comb begin
    gnt     = '0;
    win_idx = '0;
    xfer    = 1'b0;
    if (!i_rst) begin
      if (cpu_wins) begin
        gnt[REQ_CPU] = 1'b1;
        win_idx      = IW'(REQ_CPU);
        xfer         = 1'b1;
      end else if (pick_any) begin
        gnt     = pick_gnt;
        win_idx = pick_idx;
        xfer    = 1'b1;
      end
    end
  end

  assign o_gnt     = gnt;
  assign sel_we    = i_we[win_idx];
  assign sel_addr  = i_addr[win_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = i_wdata[win_idx*DATA_W +: DATA_W];

  always_comb begin
    rr_d = rr_q;
    if (xfer && ((CPU_PRIO == 0) || (win_idx != IW'(REQ_CPU)))) begin
      if (win_idx == IW'(NUM_REQ - 1)) rr_d = IW'(RR_LO);
      else                             rr_d = win_idx + 1'b1;
    end
  end

  always_comb begin
    run_d = run_q;
    if (xfer && (win_idx == IW'(REQ_CPU)) && others_pending) begin
      if (run_q != RUN_W'(MAX_RUN)) run_d = run_q + 1'b1;
    end else if ((xfer && (win_idx != IW'(REQ_CPU))) || !others_pending) begin
      run_d = '0;
    end
  end

  always_comb begin
    rvalid_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rvalid_d[k] = stage2_q.valid && (stage2_q.id == TAG_ID_W'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q        <= IW'(REQ_DMA);
      run_q       <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
      stage1_q    <= TAG_EMPTY;
      stage2_q    <= TAG_EMPTY;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      run_q     <= run_d;
      bram_we_q <= xfer & sel_we;
      // Address/data hold between transfers so the BRAM port stays quiet.
      if (xfer) begin
        bram_addr_q <= sel_addr;
        bram_di_q   <= sel_wdata;
      end
      stage1_q <= '{valid: xfer & ~sel_we, id: TAG_ID_W'(win_idx)};
      stage2_q <= stage1_q;
      // stage2 lines up with the cycle in which the BRAM output is valid.
      rdata_q  <= i_bram_do;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_bram_we   = bram_we_q;
  assign o_bram_addr = bram_addr_q;
  assign o_bram_di   = bram_di_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_busy      = stage1_q.valid | stage2_q.valid;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  localparam int N       = 3;
  localparam int AW      = 16;
  localparam int DW      = 8;
  localparam int MAX_RUN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v = '0;
  logic [N-1:0]    we_v  = '0;
  logic [N*AW-1:0] addr_v = '0;
  logic [N*DW-1:0] wd_v  = '0;

  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, bram_di, bram_do;
  logic            bram_we, busy;
  logic [AW-1:0]   bram_addr;

  bram_port_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .CPU_PRIO (1), .MAX_RUN (MAX_RUN)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req_v),
    .i_we        (we_v),
    .i_addr      (addr_v),
    .i_wdata     (wd_v),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_bram_we   (bram_we),
    .o_bram_addr (bram_addr),
    .o_bram_di   (bram_di),
    .i_bram_do   (bram_do),
    .o_busy      (busy)
  );

  function automatic logic [7:0] init_val(logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  // ---------------- BRAM environment (synchronous, read-first) ----------------
  logic          mem_init = 1'b1;
  logic [DW-1:0] mem [65536];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
    end else if (bram_we) begin
      mem[bram_addr] <= bram_di;
    end
    bram_do <= mem[bram_addr];
  end

  // ---------------- reference model ----------------
  logic [7:0]  shadow [int];
  logic [31:0] exp_q [$];  // {due_cycle[19:0], id[3:0], data[7:0]}
  int m_rr = 1;
  int m_run = 0;
  int cyc = 0;
  logic prev_xfer = 1'b0;
  logic prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wd = '0;

  int checks = 0;
  int errors = 0;

  int gnt_log [$];
  int rv_id_log [$];
  int rv_cyc_log [$];
  logic [7:0] rv_dat_log [$];
  int we_pulses = 0;

  function automatic logic [7:0] shadow_rd(logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  function automatic int model_winner();
    logic others;
    others = |req_v[N-1:1];
    if (req_v == '0) return -1;
    if (req_v[0] && !(m_run == MAX_RUN && others)) return 0;
    for (int i = 0; i < N - 1; i++) begin
      automatic int k = 1 + ((m_rr - 1 + i) % (N - 1));
      if (req_v[k]) return k;
    end
    return -1;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_v[k] = 1'b1;
    we_v[k]  = w;
    addr_v[k*AW +: AW] = a;
    wd_v[k*DW +: DW]   = d;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rv_id_log.delete();
    rv_cyc_log.delete();
    rv_dat_log.delete();
    we_pulses = 0;
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic step();
    int w, dw;
    logic [N-1:0] eg, erv;
    logic [7:0] erd;
    logic ebusy, others;
    logic [31:0] e;
    logic [AW-1:0] a;
    @(negedge clk);
    w  = model_winner();
    eg = (w >= 0) ? (N'(1) << w) : '0;
    check_eq("gnt", 32'(gnt), 32'(eg));
    erv = '0;
    erd = '0;
    if (exp_q.size() > 0 && exp_q[0][31:12] == 20'(cyc)) begin
      e = exp_q.pop_front();
      erv[e[11:8]] = 1'b1;
      erd = e[7:0];
    end
    check_eq("rvalid", 32'(rvalid), 32'(erv));
    if (erv != '0) check_eq("rdata", 32'(rdata), 32'(erd));
    ebusy = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][31:12] == 20'(cyc + 1) || exp_q[i][31:12] == 20'(cyc + 2)) ebusy = 1'b1;
    check_eq("busy", 32'(busy), 32'(ebusy));
    check_eq("bram_we", 32'(bram_we), 32'(prev_wr));
    if (prev_xfer) check_eq("bram_addr", 32'(bram_addr), 32'(prev_addr));
    if (prev_wr) check_eq("bram_di", 32'(bram_di), 32'(prev_wd));
    if (bram_we) we_pulses++;
    dw = -1;
    for (int k = 0; k < N; k++) if (gnt[k]) dw = k;
    gnt_log.push_back(dw);
    for (int k = 0; k < N; k++) if (rvalid[k]) begin
      rv_id_log.push_back(k);
      rv_cyc_log.push_back(cyc);
      rv_dat_log.push_back(rdata);
    end
    // advance model by the transfer the spec rules pick
    others    = |req_v[N-1:1];
    prev_xfer = (w >= 0);
    prev_wr   = (w >= 0) && we_v[w];
    if (w >= 0) begin
      a         = addr_v[w*AW +: AW];
      prev_addr = a;
      prev_wd   = wd_v[w*DW +: DW];
      if (we_v[w]) shadow[int'(a)] = wd_v[w*DW +: DW];
      else exp_q.push_back({20'(cyc + 3), 4'(w), shadow_rd(a)});
    end
    if (w > 0) begin
      m_rr  = (w == N - 1) ? 1 : w + 1;
      m_run = 0;
    end else if (w == 0 && others) begin
      if (m_run < MAX_RUN) m_run++;
    end else if (!others) begin
      m_run = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (w >= 0) req_v[w] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_v = '0;
    exp_q.delete();
    m_rr = 1;
    m_run = 0;
    prev_xfer = 1'b0;
    prev_wr = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_eq("rst_gnt", 32'(gnt), 0);
      check_eq("rst_rvalid", 32'(rvalid), 0);
      check_eq("rst_rdata", 32'(rdata), 0);
      check_eq("rst_we", 32'(bram_we), 0);
      check_eq("rst_addr", 32'(bram_addr), 0);
      check_eq("rst_di", 32'(bram_di), 0);
      check_eq("rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    mem_init = 1'b0;
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g0;
    do_reset(3);
    idle(2);

    // single CPU read of 0x1234
    clear_logs();
    g0 = cyc;
    issue(0, 1'b0, 16'h1234, 8'h00);
    idle(5);
    check_eq("cpu_rd_gnt", 32'(gnt_log[0]), 0);
    check_eq("cpu_rd_count", 32'(rv_id_log.size()), 1);
    if (rv_id_log.size() == 1) begin
      check_eq("cpu_rd_lat", 32'(rv_cyc_log[0] - g0), 3);
      check_eq("cpu_rd_data", 32'(rv_dat_log[0]), 32'h A5);
    end

    // write then read-after-write by req1
    clear_logs();
    issue(1, 1'b1, 16'h0010, 8'h5A);
    step();
    issue(1, 1'b0, 16'h0010, 8'h00);
    idle(5);
    check_eq("raw_we_pulses", 32'(we_pulses), 1);
    check_eq("raw_count", 32'(rv_id_log.size()), 1);
    if (rv_dat_log.size() == 1) check_eq("raw_data", 32'(rv_dat_log[0]), 32'h5A);

    // req1 and req2 continuous, CPU idle
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      if (!req_v[1]) issue(1, 1'b0, 16'h0100 + 16'(i), 8'h00);
      if (!req_v[2]) issue(2, 1'b0, 16'h0200 + 16'(i), 8'h00);
      step();
    end
    for (int i = 1; i < 8; i++)
      check_eq("rr_alternate", 32'((gnt_log[i] > 0) && (gnt_log[i] != gnt_log[i-1])), 1);
    req_v = '0;
    idle(4);

    // CPU and req2 continuous: 0,0,0,0,2 repeating
    clear_logs();
    for (int i = 0; i < 15; i++) begin
      if (!req_v[0]) issue(0, 1'b0, 16'h0300 + 16'(i), 8'h00);
      if (!req_v[2]) issue(2, 1'b0, 16'h0400 + 16'(i), 8'h00);
      step();
    end
    for (int i = 0; i < 15; i++)
      check_eq("run_pattern", 32'(gnt_log[i]), (i % 5 == 4) ? 32'd2 : 32'd0);
    req_v = '0;
    idle(4);

    // reads by 0,1,2 on consecutive cycles
    clear_logs();
    issue(0, 1'b0, 16'h0500, 8'h00);
    step();
    issue(1, 1'b0, 16'h0501, 8'h00);
    step();
    issue(2, 1'b0, 16'h0502, 8'h00);
    idle(5);
    check_eq("seq_count", 32'(rv_id_log.size()), 3);
    if (rv_id_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("seq_id", 32'(rv_id_log[i]), 32'(i));
        check_eq("seq_cyc", 32'(rv_cyc_log[i] - rv_cyc_log[0]), 32'(i));
        check_eq("seq_data", 32'(rv_dat_log[i]), 32'(init_val(16'h0500 + 16'(i))));
      end
    end

    // reset one cycle after a read handshake
    clear_logs();
    issue(0, 1'b0, 16'h1234, 8'h00);
    step();
    do_reset(2);
    idle(6);
    check_eq("rst_drop_count", 32'(rv_id_log.size()), 0);
    issue(0, 1'b0, 16'h1234, 8'h00);
    idle(5);
    check_eq("rst_resume_count", 32'(rv_id_log.size()), 1);
    if (rv_dat_log.size() == 1) check_eq("rst_resume_data", 32'(rv_dat_log[0]), 32'hA5);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_v[k] && $urandom_range(0, 2) == 0)
          issue(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      step();
    end
    req_v = '0;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
